// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: PC-controller/hazard inputs, instruction memory port, and
// the IF/ID pipeline register outputs, plus the fetch FSM state for debug.
interface pc_fetch_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  // valid_id_o qualifies pc_id_o/pc_plus_id_o/instr_id_o; there is no ready,
  // back-pressure arrives as stall_i and holds every IF/ID output unchanged.
  logic                   stall_i;
  logic                   pc_select_i;
  logic                   clear_pipes_i;
  logic [PC_WIDTH-1:0]    branch_target_i;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic [PC_WIDTH-1:0]    pc_id_o;
  logic [PC_WIDTH-1:0]    pc_plus_id_o;
  logic [INSTR_WIDTH-1:0] instr_id_o;
  logic                   valid_id_o;
  logic [1:0]             fetch_state;

  modport master (
    output stall_i, pc_select_i, clear_pipes_i, branch_target_i, instr_i,
    input  imem_addr_o, pc_id_o, pc_plus_id_o, instr_id_o, valid_id_o,
           fetch_state
  );

  modport slave (
    input  stall_i, pc_select_i, clear_pipes_i, branch_target_i, instr_i,
    output imem_addr_o, pc_id_o, pc_plus_id_o, instr_id_o, valid_id_o,
           fetch_state
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, zero-latency imem address, IF/ID register, redirect bubbles.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o / flush_cnt_o performance counters.
module pc_fetch_stage #(
  parameter int unsigned         PC_WIDTH      = 32,
  parameter int unsigned         INSTR_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int unsigned         PC_STEP       = 4,
  parameter int unsigned         FLUSH_BUBBLES = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pc_fetch_if.slave  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [PC_WIDTH-1:0] STEP        = PC_WIDTH'(PC_STEP);
  localparam logic [1:0]          BUBBLES     = 2'(FLUSH_BUBBLES);
  localparam bit                  HAS_BUBBLES = (FLUSH_BUBBLES > 0);

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [1:0]             bub_cnt;
  logic [1:0]             bub_cnt_next;
  logic [1:0]             bub_step;

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [PC_WIDTH-1:0]    pc_seq;
  logic                   id_load;
  logic                   id_kill;

  logic [PC_WIDTH-1:0]    pc_id;
  logic [PC_WIDTH-1:0]    pc_plus_id;
  logic [INSTR_WIDTH-1:0] instr_id;
  logic                   valid_id;

  // Sequential increment wraps modulo 2^PC_WIDTH by construction.
  assign pc_seq = pc + STEP;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_BOOT;
      bub_cnt <= '0;
    end else begin
      state   <= state_next;
      bub_cnt <= bub_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bub_cnt_next = bub_cnt;
    bub_step     = '0;
    case (state)
      S_BOOT: state_next = S_RUN;
      S_RUN: begin
        if (bus.pc_select_i && HAS_BUBBLES) begin
          state_next   = S_REDIRECT;
          bub_cnt_next = '0;
        end
      end
      S_REDIRECT: begin
        // A fresh redirect while draining counts itself as bubble number one.
        bub_step = bus.pc_select_i ? 2'd1 : bub_cnt + 2'd1;
        if (bub_step >= BUBBLES) begin
          state_next   = S_RUN;
          bub_cnt_next = '0;
        end else begin
          bub_cnt_next = bub_step;
        end
      end
      default: begin
        state_next   = S_BOOT;
        bub_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    pc_next = pc;
    id_load = 1'b0;
    id_kill = 1'b0;
    case (state)
      S_BOOT: id_kill = 1'b1;
      S_RUN: begin
        if (bus.pc_select_i) begin
          pc_next = bus.branch_target_i;
          id_kill = 1'b1;
        end else if (bus.clear_pipes_i) begin
          pc_next = pc_seq;
          id_kill = 1'b1;
        end else if (!bus.stall_i) begin
          pc_next = pc_seq;
          id_load = 1'b1;
        end
      end
      S_REDIRECT: begin
        id_kill = 1'b1;
        if (bus.pc_select_i) pc_next = bus.branch_target_i;
      end
      default: id_kill = 1'b1;
    endcase
  end

  // Killed slots only drop valid; stale payload stays for consumers to ignore.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc         <= RESET_VECTOR;
      pc_id      <= '0;
      pc_plus_id <= '0;
      instr_id   <= '0;
      valid_id   <= 1'b0;
    end else begin
      pc <= pc_next;
      if (id_load) begin
        pc_id      <= pc;
        pc_plus_id <= pc_seq;
        instr_id   <= bus.instr_i;
        valid_id   <= 1'b1;
      end else if (id_kill) begin
        valid_id   <= 1'b0;
      end
    end
  end

  assign bus.imem_addr_o  = pc;
  assign bus.pc_id_o      = pc_id;
  assign bus.pc_plus_id_o = pc_plus_id;
  assign bus.instr_id_o   = instr_id;
  assign bus.valid_id_o   = valid_id;
  assign bus.fetch_state  = state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  logic        flush_ev;

  assign flush_ev = ((state == S_RUN) || (state == S_REDIRECT)) &&
                    (bus.pc_select_i || bus.clear_pipes_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_load)  fetch_cnt <= fetch_cnt + 32'd1;
      if (flush_ev) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: dut_a with no redirect bubbles, dut_b with
// FLUSH_BUBBLES = 2; instruction memory returns 0xA0 + address.
module tb_pc_fetch_stage;

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   vectors;
  int   miscompares;

  pc_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) a_if ();
  pc_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) b_if ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_a;
  logic [31:0] flush_cnt_a;
  logic [31:0] fetch_cnt_b;
  logic [31:0] flush_cnt_b;
`endif

  pc_fetch_stage #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_VECTOR(32'h0),
    .PC_STEP(4), .FLUSH_BUBBLES(0)
  ) dut_a (
    .clk_i(clk),
    .rst_i(rst_a),
    .bus  (a_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o(fetch_cnt_a),
    .flush_cnt_o(flush_cnt_a)
`endif
  );

  pc_fetch_stage #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_VECTOR(32'h0),
    .PC_STEP(4), .FLUSH_BUBBLES(2)
  ) dut_b (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (b_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o(fetch_cnt_b),
    .flush_cnt_o(flush_cnt_b)
`endif
  );

  // Combinational instruction memory model.
  assign a_if.instr_i = 32'hA0 + a_if.imem_addr_o;
  assign b_if.instr_i = 32'hA0 + b_if.imem_addr_o;

  // Clock/reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic stall, input logic sel, input logic clr,
                         input logic [31:0] tgt);
    a_if.stall_i         = stall;
    a_if.pc_select_i     = sel;
    a_if.clear_pipes_i   = clr;
    a_if.branch_target_i = tgt;
  endtask

  task automatic drive_b(input logic stall, input logic sel, input logic clr,
                         input logic [31:0] tgt);
    b_if.stall_i         = stall;
    b_if.pc_select_i     = sel;
    b_if.clear_pipes_i   = clr;
    b_if.branch_target_i = tgt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_id_a(input string tag, input logic [31:0] addr,
                            input logic [31:0] pc_id, input logic [31:0] instr,
                            input logic valid);
    check({tag, ".addr"},  a_if.imem_addr_o, addr);
    check({tag, ".pc_id"}, a_if.pc_id_o,     pc_id);
    check({tag, ".instr"}, a_if.instr_id_o,  instr);
    check({tag, ".valid"}, 32'(a_if.valid_id_o), 32'(valid));
  endtask

  task automatic check_id_b(input string tag, input logic [31:0] addr,
                            input logic [31:0] pc_id, input logic valid,
                            input logic [1:0] st);
    check({tag, ".addr"},  b_if.imem_addr_o, addr);
    check({tag, ".pc_id"}, b_if.pc_id_o,     pc_id);
    check({tag, ".valid"}, 32'(b_if.valid_id_o), 32'(valid));
    check({tag, ".state"}, 32'(b_if.fetch_state), 32'(st));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // Reset state of dut_a.
    check_id_a("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.pc_plus", a_if.pc_plus_id_o, 32'h0);
    check("rst.state", 32'(a_if.fetch_state), 32'(S_BOOT));
    rst_a = 1'b0;

    // Boot cycle, then sequential fetch.
    tick();
    check_id_a("boot", 32'h0, 32'h0, 32'h0, 1'b0);
    check("boot.state", 32'(a_if.fetch_state), 32'(S_RUN));
    tick();
    check_id_a("seq0", 32'h4, 32'h0, 32'hA0, 1'b1);
    check("seq0.pc_plus", a_if.pc_plus_id_o, 32'h4);
    tick();
    check_id_a("seq1", 32'h8, 32'h4, 32'hA4, 1'b1);

    // Stall three cycles at PC = 8.
    drive_a(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_id_a("stall", 32'h8, 32'h4, 32'hA4, 1'b1);
    end
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_a("unstall", 32'hC, 32'h8, 32'hA8, 1'b1);
    tick();
    check_id_a("seq2", 32'h10, 32'hC, 32'hAC, 1'b1);

    // Redirect to 0x40 at PC = 0x10; bubble keeps the previous payload.
    drive_a(1'b0, 1'b1, 1'b0, 32'h40);
    tick();
    check_id_a("redir", 32'h40, 32'hC, 32'hAC, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_a("redir_tgt", 32'h44, 32'h40, 32'hE0, 1'b1);
    check("redir_tgt.pc_plus", a_if.pc_plus_id_o, 32'h44);

    // Flush together with stall: flush wins, PC still advances.
    drive_a(1'b1, 1'b0, 1'b1, 32'h0);
    tick();
    check_id_a("clr_stall", 32'h48, 32'h40, 32'hE0, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_a("post_clr", 32'h4C, 32'h48, 32'hE8, 1'b1);

    // Redirect together with stall: redirect wins.
    drive_a(1'b1, 1'b1, 1'b0, 32'h20);
    tick();
    check_id_a("sel_stall", 32'h20, 32'h48, 32'hE8, 1'b0);
    check("sel_stall.state", 32'(a_if.fetch_state), 32'(S_RUN));
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_a("sel_stall_tgt", 32'h24, 32'h20, 32'hC0, 1'b1);

    // PC wrap at the top of the address space.
    drive_a(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    tick();
    check_id_a("to_top", 32'hFFFF_FFFC, 32'h20, 32'hC0, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_a("wrap", 32'h0, 32'hFFFF_FFFC, 32'h9C, 1'b1);
    check("wrap.pc_plus", a_if.pc_plus_id_o, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    check("a.fetch_cnt", fetch_cnt_a, 32'd8);
    check("a.flush_cnt", flush_cnt_a, 32'd4);
`endif

    // Mid-run reset of dut_a.
    rst_a = 1'b1;
    tick();
    check_id_a("a_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("a_rst.state", 32'(a_if.fetch_state), 32'(S_BOOT));
`ifdef FETCH_PERF_CNT_EN
    check("a_rst.fetch_cnt", fetch_cnt_a, 32'd0);
`endif
    rst_a = 1'b0;

    // dut_b: two redirect bubbles.
    rst_b = 1'b0;
    tick();
    check_id_b("b_boot", 32'h0, 32'h0, 1'b0, S_RUN);
    tick();
    check_id_b("b_seq0", 32'h4, 32'h0, 1'b1, S_RUN);
    drive_b(1'b0, 1'b1, 1'b0, 32'h80);
    tick();
    check_id_b("b_redir", 32'h80, 32'h0, 1'b0, S_REDIRECT);
    // Stall is ignored while draining bubbles.
    drive_b(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_b("b_bub1", 32'h80, 32'h0, 1'b0, S_REDIRECT);
    tick();
    check_id_b("b_bub2", 32'h80, 32'h0, 1'b0, S_RUN);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_b("b_tgt", 32'h84, 32'h80, 1'b1, S_RUN);
    check("b_tgt.instr", b_if.instr_id_o, 32'h120);

    // Redirect arriving during bubbles restarts the count at one.
    drive_b(1'b0, 1'b1, 1'b0, 32'h100);
    tick();
    check_id_b("b_re1", 32'h100, 32'h80, 1'b0, S_REDIRECT);
    drive_b(1'b0, 1'b1, 1'b0, 32'h200);
    tick();
    check_id_b("b_re2", 32'h200, 32'h80, 1'b0, S_REDIRECT);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_id_b("b_re3", 32'h200, 32'h80, 1'b0, S_RUN);
    tick();
    check_id_b("b_re_tgt", 32'h204, 32'h200, 1'b1, S_RUN);
    check("b_re_tgt.pc_plus", b_if.pc_plus_id_o, 32'h204);

`ifdef FETCH_PERF_CNT_EN
    check("b.fetch_cnt", fetch_cnt_b, 32'd3);
    check("b.flush_cnt", flush_cnt_b, 32'd3);
`endif

    // Reset while in S_REDIRECT.
    drive_b(1'b0, 1'b1, 1'b0, 32'h80);
    tick();
    check_id_b("b_redir2", 32'h80, 32'h200, 1'b0, S_REDIRECT);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);
    rst_b = 1'b1;
    tick();
    check_id_b("b_rst", 32'h0, 32'h0, 1'b0, S_BOOT);
    check("b_rst.instr", b_if.instr_id_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
